mem1rw_req_ctrl: RTL and testbench
==================================

MEM1RW_REQ_CTRL -- requirements
Module: mem1rw_req_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 5, which sets the memory word-address width.
REQ-002 The block SHALL have the parameter DATA_W, default 64, which sets the data width.
REQ-003 The block SHALL have the parameter DEPTH, default 4, which sets the response FIFO entries; DEPTH SHALL be a power of two and at least 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports in this order:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous active-low reset; 0 resets all state.
REQ-005 The block SHALL have these upstream request ports:
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid=1 and req_ready=1.
- req_write  input  1  1=write, 0=read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
REQ-006 The block SHALL have these response ports:
- resp_valid  output  1  read data available.
- resp_ready  input  1  consumer takes the data when resp_valid=1 and resp_ready=1.
- resp_rdata  output  DATA_W  read data, returned in request order.
REQ-007 The block SHALL have these memory-side ports, which drive a single-port memory with a registered read address:
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after the read address is presented with mem_we=0.
REQ-008 The block SHALL have the port count  output  $clog2(DEPTH)+1  holding the current response FIFO occupancy.

Function
REQ-009 An accepted request is called a fire; fire = req_valid & req_ready.
REQ-010 req_ready SHALL equal (count + inflight < DEPTH); it SHALL be computed from registers only and SHALL NOT depend on resp_ready or req_valid.
REQ-011 mem_addr SHALL equal req_addr and mem_wdata SHALL equal req_wdata combinationally in every cycle.
REQ-012 mem_we SHALL equal fire & req_write; mem_we SHALL be 0 whenever reset=0.
REQ-013 A write fire SHALL update the memory at the same clock edge and SHALL produce no response.
REQ-014 A read fire SHALL set the inflight register to 1 at the next edge; when no read fires, inflight SHALL clear to 0 at the next edge.
REQ-015 In a cycle with inflight=1, the block SHALL write mem_rdata into the FIFO tail at the end of that cycle; read latency from fire to resp_valid SHALL be exactly 2 cycles when the FIFO is empty.
REQ-016 The FIFO SHALL use head and tail pointers that wrap modulo DEPTH; resp_rdata SHALL be the head entry and resp_valid SHALL equal (count != 0).
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged and SHALL advance both pointers.
REQ-018 With DEPTH>=3 and resp_ready held at 1, back-to-back reads SHALL sustain one fire per cycle.
REQ-019 Overflow SHALL be impossible by REQ-010; a push while count=DEPTH is a design error and SHALL trigger a simulation assertion.
REQ-020 A read to an address written in the immediately preceding fire SHALL return the newly written data.
REQ-021 resp_rdata SHALL hold stable while resp_valid=1 and resp_ready=0.

Reset
REQ-022 While reset=0, count, inflight, head and tail SHALL be 0, so resp_valid=0 and req_ready=1; FIFO data contents need not be reset.
REQ-023 Asserting reset during outstanding reads SHALL discard the in-flight read and all queued responses, and no response SHALL appear after release.
REQ-024 The first fire after reset SHALL be allowed in the first rising edge after reset deasserts.

Verification
REQ-025 The bench SHALL cover these scenarios:
- write addr 3 with 0xDEADBEEF_00000001, then read addr 3 with resp_ready=1 -> resp_valid=1 exactly 2 cycles after the read fire, with rdata 0xDEADBEEF_00000001.
- 32 back-to-back reads of addresses 0..31 with resp_ready=1 and DEPTH=4 -> req_ready stays 1 and the responses arrive in address order, one per cycle.
- resp_ready=0 while issuing reads -> at most 4 fires, count reaches 4 with inflight=0, and req_ready=0 until one pop occurs.
- push and pop in the same cycle with count=2 -> count stays 2 and the pointers wrap correctly across the DEPTH boundary.
- reset=0 pulsed while count=3 and inflight=1 -> after release resp_valid=0, count=0, req_ready=1, and no stale response appears.
- a write fire while resp_ready=0 and the FIFO is full -> req_ready=0 blocks the write and mem_we stays 0.

Source files
------------

// File: rtl/mem1rw_req_ctrl_if.sv
// Request, response and memory-side signals of mem1rw_req_ctrl.
// slave is the controller's view; master is the upstream/memory environment.
interface mem1rw_req_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem1rw_req_ctrl.sv
// Request controller for a single-port memory with registered read data;
// read results are queued in a small response FIFO and returned in order.
module mem1rw_req_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  mem1rw_req_ctrl_if.slave       bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [DATA_W-1:0] r_fifo [DEPTH];

  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W:0]    w_occ;
  logic              w_req_ready;

  // Occupancy counts the read still in the memory pipeline, so the FIFO can never overflow.
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_req_ready = (w_occ < (CNT_W + 1)'(DEPTH));
  assign w_fire      = bus.req_valid & w_req_ready;
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != '0) & bus.resp_ready;

  assign bus.req_ready  = w_req_ready;
  assign bus.mem_addr   = bus.req_addr;
  assign bus.mem_wdata  = bus.req_wdata;
  assign bus.mem_we     = w_fire & bus.req_write & reset;
  assign bus.resp_valid = (r_count != '0);
  assign bus.resp_rdata = r_fifo[r_head];
  assign count          = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_fire & ~bus.req_write;
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_tail] <= bus.mem_rdata;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(r_inflight && (r_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_mem1rw_req_ctrl.sv
// Bench for mem1rw_req_ctrl: behavioural memory, scoreboard of expected read data,
// a vector table plus directed sequences for backpressure, wrap and reset.
module tb_mem1rw_req_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] count;
  always #5 clk = ~clk;

  mem1rw_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem1rw_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus),
    .count (count)
  );

  // Single-port memory, read data registered one cycle after the address.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_rd;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    else            ram_rd <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_rd;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int pops  = 0;
  int last_pop = 0;
  int stalls = 0;
  logic [DW-1:0] model [32];
  logic [DW-1:0] expq [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      pops++;
      last_pop = cyc;
      if (expq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_resp: got %h with no response outstanding (cycle %0d)",
                 bus.resp_rdata, cyc);
      end else begin
        check("resp_rdata", bus.resp_rdata, expq.pop_front());
      end
    end
  end

  // Issue one request and hold it until accepted; for reads d is the expected data.
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int fire_cyc);
    bit done = 0;
    fire_cyc = -1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1;
        fire_cyc = cyc;
        if (wr) model[a] = d;
        else    expq.push_back(d);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && count == 3'd0) done = 1;
    end
    if (!done) check("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl [12];
  int   fc;
  int   fc0;
  int   p0;
  int   fires;
  bit   armed;
  bit   hit;
  logic [AW-1:0] a;

  initial begin
    tbl[0]  = '{1'b1, 5'd5,  64'hA5A5_A5A5_5A5A_5A5A};
    tbl[1]  = '{1'b0, 5'd5,  64'hA5A5_A5A5_5A5A_5A5A};
    tbl[2]  = '{1'b1, 5'd5,  64'h0123_4567_89AB_CDEF};
    tbl[3]  = '{1'b0, 5'd5,  64'h0123_4567_89AB_CDEF};
    tbl[4]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5]  = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[6]  = '{1'b1, 5'd0,  64'h0000_0000_0000_0000};
    tbl[7]  = '{1'b0, 5'd0,  64'h0000_0000_0000_0000};
    tbl[8]  = '{1'b0, 5'd3,  64'hDEAD_BEEF_0000_0001};
    tbl[9]  = '{1'b1, 5'd3,  64'hCAFE_F00D_1234_5678};
    tbl[10] = '{1'b0, 5'd3,  64'hCAFE_F00D_1234_5678};
    tbl[11] = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset state, with a write request driven to prove mem_we is gated.
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);

    // Release; the write to addr 3 must be accepted at the very next rising edge.
    rst_n = 1'b1;
    bus.req_addr  = 5'd3;
    bus.req_wdata = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("first_edge_ready", 64'(bus.req_ready), 64'd1);
    check("first_edge_we", 64'(bus.mem_we), 64'd1);
    model[3] = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    p0 = pops;
    do_req(1'b0, 5'd3, 64'hDEAD_BEEF_0000_0001, fc);
    idle();
    hit = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(posedge clk); #1;
      if (pops > p0) hit = 1;
    end
    check("read_latency", 64'(last_pop - fc), 64'd2);

    // Vector table, back-to-back including read-after-write to the same address.
    for (int unsigned i = 0; i < 12; i++) do_req(tbl[i].wr, tbl[i].addr, tbl[i].data, fc);
    idle();
    drain();

    // Fill memory, then 32 back-to-back reads of addresses 0..31.
    for (int unsigned i = 0; i < 32; i++)
      do_req(1'b1, AW'(i), {32'hC0DE_0000 | 32'(i), ~32'(i * 7)}, fc);
    stalls = 0;
    p0 = pops;
    for (int unsigned i = 0; i < 32; i++) begin
      do_req(1'b0, AW'(i), model[i], fc);
      if (i == 0) fc0 = fc;
    end
    idle();
    drain();
    check("sweep_stalls", 64'(stalls), 64'd0);
    check("sweep_pops", 64'(pops - p0), 64'd32);
    check("sweep_span", 64'(last_pop - fc0), 64'd33);

    // Backpressure: hold a read with resp_ready=0; exactly DEPTH fires.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 5'd10;
    fires = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        fires++;
        expq.push_back(model[10]);
      end
    end
    check("full_fires", 64'(fires), 64'd4);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.req_write = 1'b1;
    bus.req_wdata = 64'h1111_2222_3333_4444;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("full_write_we", 64'(bus.mem_we), 64'd0);
      check("full_write_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    idle();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("after_pop_count", 64'(count), 64'd3);
    check("after_pop_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    drain();
    do_req(1'b0, 5'd10, model[10], fc);
    idle();
    drain();

    // Simultaneous push and pop at count=2 across several pointer wraps.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    a = 5'd16;
    bus.req_addr = a;
    armed = 0;
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        expq.push_back(model[a]);
        a = a + 5'd1;
      end
      if (count == 3'd1) armed = 1;
      @(posedge clk); #1;
      bus.req_addr = a;
      if (armed) begin
        bus.resp_ready = 1'b1;
        hit = 1;
      end
    end
    check("wrap_armed", 64'(hit), 64'd1);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      check("wrap_count", 64'(count), 64'd2);
      if (bus.req_ready) begin
        expq.push_back(model[a]);
        a = a + 5'd1;
      end
      @(posedge clk); #1;
      bus.req_addr = a;
    end
    idle();
    drain();

    // Reset with count=3 and a read in flight; nothing may come out afterwards.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 5'd20;
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      if (count == 3'd3) hit = 1;
      else if (bus.req_ready) expq.push_back(model[20]);
    end
    check("pre_reset_count", 64'(count), 64'd3);
    check("pre_reset_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b0;
    bus.req_write = 1'b1;
    bus.req_wdata = 64'h9999_8888_7777_6666;
    expq.delete();
    #1;
    check("in_reset_count", 64'(count), 64'd0);
    check("in_reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("in_reset_mem_we", 64'(bus.mem_we), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.resp_ready = 1'b1;
    p0 = pops;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("post_reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    check("post_reset_count", 64'(count), 64'd0);
    check("post_reset_ready", 64'(bus.req_ready), 64'd1);
    check("post_reset_pops", 64'(pops - p0), 64'd0);
    @(posedge clk); #1;
    do_req(1'b0, 5'd20, model[20], fc);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
